// File: rtl/exe_pkg.sv
// Shared encodings and default widths for the execute stage.
package exe_pkg;

   localparam int unsigned DataWDef = 32;
   localparam int unsigned AddrWDef = 5;

   typedef enum logic [3:0] {
      CmdAdd = 4'd0,
      CmdSub = 4'd1,
      CmdAnd = 4'd2,
      CmdOr  = 4'd3,
      CmdNor = 4'd4,
      CmdXor = 4'd5,
      CmdSll = 4'd6,
      CmdSrl = 4'd7,
      CmdSra = 4'd8,
      CmdSlt = 4'd9,
      CmdMul = 4'd10
   } exe_cmd_e;

   typedef enum logic [1:0] {
      FwdId  = 2'd0,
      FwdMem = 2'd1,
      FwdWb  = 2'd2,
      FwdRsv = 2'd3
   } fwd_sel_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_W steps.
module exe_mul_iter
   import exe_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDef
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              hold_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic              busy_o,
   output logic              last_o,
   output logic [DATA_W-1:0] product_o
);

   localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [0:0] {StIdle, StBusy} mul_state_e;

   mul_state_e        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] mcand_q, mcand_d;
   logic [DATA_W-1:0] mplier_q, mplier_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] acc_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start_i && !abort_i && !hold_i) state_d = StBusy;
         StBusy: begin
            if (abort_i) state_d = StIdle;
            else if (!hold_i && last_o) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Accumulator value including the current step; on the last step this is the product.
   assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (abort_i) begin
         cnt_d = '0;
      end else if (state_q == StIdle) begin
         if (start_i && !hold_i) begin
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
         end
      end else if (!hold_i) begin
         cnt_d    = last_o ? '0 : cnt_q + CntW'(1);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_step;
      end
   end

   always_comb begin
      busy_o    = (state_q == StBusy);
      last_o    = busy_o && (cnt_q == CntW'(DATA_W - 1));
      product_o = acc_step;
   end

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: forwarding muxes, single-cycle ALU, iterative multiply, EX/MEM register.
module exe_stage
   import exe_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDef,
   parameter int unsigned ADDR_W = AddrWDef
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [3:0]        id_exe_cmd,
   input  logic [DATA_W-1:0] id_val1,
   input  logic [DATA_W-1:0] id_val2,
   input  logic [DATA_W-1:0] id_st_val,
   input  logic [ADDR_W-1:0] id_dest,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic              id_mem_w_en,
   input  logic [1:0]        val1_sel,
   input  logic [1:0]        val2_sel,
   input  logic [DATA_W-1:0] fwd_wb_val,
   output logic              exe_stall,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_alu_res,
   output logic [DATA_W-1:0] mem_st_val,
   output logic [ADDR_W-1:0] mem_dest,
   output logic              mem_wb_en,
   output logic              mem_mem_r_en,
   output logic              mem_mem_w_en
);

   logic [DATA_W-1:0] op_a, op_b, alu_res, mul_product;
   logic              mul_start, mul_busy, mul_last;

   logic [DATA_W-1:0] mul_st_val_q;
   logic [ADDR_W-1:0] mul_dest_q;
   logic              mul_wb_en_q, mul_r_en_q, mul_w_en_q;

   logic              valid_q, valid_d, wb_en_q, wb_en_d, r_en_q, r_en_d, w_en_q, w_en_d;
   logic [DATA_W-1:0] res_q, res_d, st_val_q, st_val_d;
   logic [ADDR_W-1:0] dest_q, dest_d;

   always_comb begin
      case (fwd_sel_e'(val1_sel))
         FwdMem:  op_a = res_q;
         FwdWb:   op_a = fwd_wb_val;
         default: op_a = id_val1;
      endcase
      case (fwd_sel_e'(val2_sel))
         FwdMem:  op_b = res_q;
         FwdWb:   op_b = fwd_wb_val;
         default: op_b = id_val2;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (id_exe_cmd)
         CmdAdd:  alu_res = op_a + op_b;
         CmdSub:  alu_res = op_a - op_b;
         CmdAnd:  alu_res = op_a & op_b;
         CmdOr:   alu_res = op_a | op_b;
         CmdNor:  alu_res = ~(op_a | op_b);
         CmdXor:  alu_res = op_a ^ op_b;
         CmdSll:  alu_res = op_a << op_b[4:0];
         CmdSrl:  alu_res = op_a >> op_b[4:0];
         CmdSra:  alu_res = $signed(op_a) >>> op_b[4:0];
         CmdSlt:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: alu_res = '0;
      endcase
   end

   // Issue stalls in its own cycle so forwarded operands are sampled exactly once.
   assign mul_start = !rst && !mul_busy && id_valid && (id_exe_cmd == CmdMul) && !freeze && !flush;
   assign exe_stall = mul_start || (mul_busy && !mul_last);

   exe_mul_iter #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .abort_i   (flush),
      .hold_i    (freeze),
      .a_i       (op_a),
      .b_i       (op_b),
      .busy_o    (mul_busy),
      .last_o    (mul_last),
      .product_o (mul_product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_st_val_q <= '0;
         mul_dest_q   <= '0;
         mul_wb_en_q  <= 1'b0;
         mul_r_en_q   <= 1'b0;
         mul_w_en_q   <= 1'b0;
      end else if (mul_start) begin
         mul_st_val_q <= id_st_val;
         mul_dest_q   <= id_dest;
         mul_wb_en_q  <= id_wb_en;
         mul_r_en_q   <= id_mem_r_en;
         mul_w_en_q   <= id_mem_w_en;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      res_d    = res_q;
      st_val_d = st_val_q;
      dest_d   = dest_q;
      wb_en_d  = wb_en_q;
      r_en_d   = r_en_q;
      w_en_d   = w_en_q;
      if (flush || (!freeze && (!id_valid || mul_start || (mul_busy && !mul_last)))) begin
         valid_d  = 1'b0;
         res_d    = '0;
         st_val_d = '0;
         dest_d   = '0;
         wb_en_d  = 1'b0;
         r_en_d   = 1'b0;
         w_en_d   = 1'b0;
      end else if (!freeze && mul_last) begin
         valid_d  = 1'b1;
         res_d    = mul_product;
         st_val_d = mul_st_val_q;
         dest_d   = mul_dest_q;
         wb_en_d  = mul_wb_en_q;
         r_en_d   = mul_r_en_q;
         w_en_d   = mul_w_en_q;
      end else if (!freeze) begin
         valid_d  = 1'b1;
         res_d    = alu_res;
         st_val_d = id_st_val;
         dest_d   = id_dest;
         wb_en_d  = id_wb_en;
         r_en_d   = id_mem_r_en;
         w_en_d   = id_mem_w_en;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         res_q    <= '0;
         st_val_q <= '0;
         dest_q   <= '0;
         wb_en_q  <= 1'b0;
         r_en_q   <= 1'b0;
         w_en_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         res_q    <= res_d;
         st_val_q <= st_val_d;
         dest_q   <= dest_d;
         wb_en_q  <= wb_en_d;
         r_en_q   <= r_en_d;
         w_en_q   <= w_en_d;
      end
   end

   assign mem_valid    = valid_q;
   assign mem_alu_res  = res_q;
   assign mem_st_val   = st_val_q;
   assign mem_dest     = dest_q;
   assign mem_wb_en    = wb_en_q;
   assign mem_mem_r_en = r_en_q;
   assign mem_mem_w_en = w_en_q;

endmodule
